// File: rtl/instruction_memory_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory as four
// big-endian byte writes per word, holding off fetch via busy while active.
module instruction_memory_loader #(
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  start_addr,
    input  logic [6:0]  word_count,
    input  logic        in_valid,
    input  logic [31:0] in_word,
    output logic        in_ready,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        WRITE,
        DONE
    } state_t;

    localparam logic [6:0] MAX_COUNT = 7'(MAX_WORDS);

    state_t      state, state_next;
    logic [7:0]  base, base_next;
    logic [6:0]  remaining, remaining_next;
    logic [6:0]  clamped_count;
    logic [6:0]  remaining_dec;
    logic [31:0] word_reg, word_next;
    logic [1:0]  idx, idx_next;
    logic        overflow_next;
    logic [7:0]  byte_next;

    always_comb begin
        clamped_count = (word_count > MAX_COUNT) ? MAX_COUNT : word_count;
        remaining_dec = remaining - 7'd1;
    end

    always_comb begin
        state_next     = state;
        base_next      = base;
        remaining_next = remaining;
        word_next      = word_reg;
        idx_next       = idx;
        overflow_next  = overflow;

        case (state)
            IDLE: begin
                if (start) begin
                    base_next      = {start_addr[7:2], 2'b00};
                    remaining_next = clamped_count;
                    overflow_next  = 1'b0;
                    state_next     = (clamped_count == 7'd0) ? DONE : ACCEPT;
                end
            end
            ACCEPT: begin
                if (in_valid) begin
                    word_next  = in_word;
                    idx_next   = 2'd0;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (idx == 2'd3) begin
                    base_next      = base + 8'd4;
                    remaining_next = remaining_dec;
                    // Wrap only counts as overflow if more words still follow.
                    if (base == 8'hFC && remaining_dec != 7'd0) begin
                        overflow_next = 1'b1;
                    end
                    state_next = (remaining_dec == 7'd0) ? DONE : ACCEPT;
                end else begin
                    idx_next = idx + 2'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        byte_next = '0;
        case (idx_next)
            2'd0: byte_next = word_next[31:24];
            2'd1: byte_next = word_next[23:16];
            2'd2: byte_next = word_next[15:8];
            2'd3: byte_next = word_next[7:0];
            default: byte_next = '0;
        endcase
    end

    always_comb begin
        in_ready = (state == ACCEPT);
        busy     = (state != IDLE);
        done     = (state == DONE);
    end

    // Write port is registered from next-state values so it lines up with WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            base      <= '0;
            remaining <= '0;
            word_reg  <= '0;
            idx       <= '0;
            overflow  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_next;
            base      <= base_next;
            remaining <= remaining_next;
            word_reg  <= word_next;
            idx       <= idx_next;
            overflow  <= overflow_next;
            mem_we    <= (state_next == WRITE);
            mem_addr  <= base_next + {6'b000000, idx_next};
            mem_wdata <= byte_next;
        end
    end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Randomized self-checking bench for instruction_memory_loader against a
// byte-stream / arithmetic model of the expected memory writes.
module tb_instruction_memory_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  start_addr;
    logic [6:0]  word_count;
    logic        in_valid;
    logic [31:0] in_word;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        overflow;

    instruction_memory_loader #(.MAX_WORDS(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_word    (in_word),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [7:0]  exp_addr_q[$];
    logic [7:0]  exp_data_q[$];
    int          window = 0;
    logic [7:0]  mem [256];
    logic [31:0] words [64];

    always @(posedge clk) begin
        if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Each handshake must be followed by exactly four byte writes, in model order.
    always @(negedge clk) begin
        logic [7:0] ea, ed;
        check("we_window", 32'(mem_we), 32'(window > 0));
        if (mem_we === 1'b1) begin
            check("ready_in_write", 32'(in_ready), 32'd0);
            if (exp_addr_q.size() > 0) begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                check("write_addr", 32'(mem_addr), 32'(ea));
                check("write_data", 32'(mem_wdata), 32'(ed));
            end else begin
                total++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
            end
        end
        if (window > 0) window--;
        if (reset === 1'b1) begin
            window = 0;
            exp_addr_q.delete();
            exp_data_q.delete();
        end else if (in_valid === 1'b1 && in_ready === 1'b1) begin
            window = 4;
        end
    end

    task automatic run_load(input logic [7:0] addr, input logic [6:0] cnt, input int vprob,
                            input bit glitch, input int reset_word, input logic [31:0] first_word);
        int n, base, widx, cyc, wcount, last_hs, done_cyc, k, kk, exp_done;
        bit hs, exp_ov, did_reset;
        base = int'(addr) & 32'hFC;
        n = (int'(cnt) > 64) ? 64 : int'(cnt);
        for (int i = 0; i < n; i++) begin
            words[i] = (i == 0) ? first_word : $urandom;
            for (int b = 0; b < 4; b++) begin
                exp_addr_q.push_back(8'((base + 4 * i + b) % 256));
                exp_data_q.push_back(8'(words[i] >> (24 - 8 * b)));
            end
        end
        start = 1'b1;
        start_addr = addr;
        word_count = cnt;
        @(posedge clk); #1;
        start = 1'b0;
        start_addr = 8'($urandom);
        word_count = 7'($urandom);
        cyc = 1; widx = 0; wcount = 0; last_hs = -100; done_cyc = -1; did_reset = 0;
        while (cyc < 4000) begin
            in_valid = (widx < n) && (int'($urandom_range(99)) < vprob);
            in_word  = (widx < n) ? words[widx] : $urandom;
            if (glitch && (cyc == 2 || cyc == 4)) begin
                start = 1'b1;
                start_addr = 8'($urandom);
                word_count = 7'($urandom);
            end else begin
                start = 1'b0;
            end
            if (reset_word >= 0 && widx == reset_word + 1 && last_hs == cyc - 1) reset = 1'b1;
            @(negedge clk);
            check("busy_active", 32'(busy), 32'd1);
            k  = wcount / 4;
            kk = (k < n - 1) ? k : n - 1;
            exp_ov = (n > 0) && (base + 4 * kk >= 256);
            check("overflow_track", 32'(overflow), 32'(exp_ov));
            hs = (in_valid === 1'b1) && (in_ready === 1'b1);
            if (hs) last_hs = cyc;
            if (mem_we === 1'b1) wcount++;
            if (done === 1'b1) done_cyc = cyc;
            @(posedge clk); #1;
            if (hs) widx++;
            cyc++;
            if (reset === 1'b1) begin
                reset = 1'b0;
                did_reset = 1;
                break;
            end
            if (done_cyc >= 0) break;
        end
        start = 1'b0;
        in_valid = 1'b0;
        if (did_reset) begin
            @(negedge clk);
            check("rst_mem_we", 32'(mem_we), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_overflow", 32'(overflow), 32'd0);
            check("rst_mem_addr", 32'(mem_addr), 32'd0);
            check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
            check("rst_partial_bytes", 32'(wcount - 4 * reset_word), 32'd1);
            @(posedge clk); #1;
            return;
        end
        if (done_cyc < 0) begin
            total++;
            $display("FAIL load_timeout: got no done expected done within 4000 cycles");
            return;
        end
        exp_done = (n == 0) ? 1 : last_hs + 5;
        check("done_cycle", 32'(done_cyc), 32'(exp_done));
        check("byte_writes", 32'(wcount), 32'(4 * n));
        check("words_taken", 32'(widx), 32'(n));
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);
        check("overflow_final", 32'(overflow), 32'((n > 0) && (base + 4 * n > 256)));
        check("queue_drained", 32'(exp_addr_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        start_addr = 8'h20;
        word_count = 7'd5;
        in_valid = 1'b0;
        in_word = '0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        check("reset_mem_wdata", 32'(mem_wdata), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("start_in_reset_ignored", 32'(busy), 32'd0);
        @(posedge clk); #1;

        run_load(8'h00, 7'd1, 100, 0, -1, 32'h12345678);
        check("readback", {mem[0], mem[1], mem[2], mem[3]}, 32'h12345678);
        check("byte_0x01", 32'(mem[1]), 32'h34);

        run_load(8'h13, 7'd3, 40, 0, -1, 32'hDEADBEEF);
        check("aligned_first_byte", 32'(mem[8'h10]), 32'hDE);

        run_load(8'hF8, 7'd3, 70, 0, -1, 32'hCAFEF00D);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("overflow_sticky_idle", 32'(overflow), 32'd1);
        @(posedge clk); #1;

        run_load(8'h00, 7'd0, 100, 0, -1, 32'h0);
        run_load(8'h24, 7'd4, 60, 1, -1, 32'h0BADC0DE);
        run_load(8'h40, 7'd2, 100, 0, 1, 32'hA5A55A5A);
        run_load(8'h80, 7'd2, 100, 0, -1, 32'h01020304);
        run_load(8'hFC, 7'd127, 80, 0, -1, 32'h89ABCDEF);

        for (int r = 0; r < 6; r++) begin
            run_load(8'($urandom), 7'($urandom), int'($urandom_range(30, 100)),
                     1'($urandom_range(0, 1)), -1, $urandom);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/instruction_memory_loader.md
# instruction_memory_loader

Writer side of the 256-byte instruction memory: accepts 32-bit instruction words over a valid/ready stream and writes each word into the byte-wide memory as four consecutive byte writes, big-endian (MSB at the lowest address). Sits between the program source (testbench or boot stream) and the instruction memory write port. While it runs, the fetch path is held off via `busy`.

## Interface
- `MAX_WORDS`, default 64: largest accepted `word_count`; larger requests are clamped to this value.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request to begin a load; honoured only in IDLE.
- `start_addr` in 8: first byte address of the load; bits [1:0] are forced to 0 (word-aligned).
- `word_count` in 7: number of words to load; 0 is legal.
- `in_valid` in 1: source presents `in_word`.
- `in_word` in 32: instruction word; bit 31 is the MSB.
- `in_ready` out 1: loader accepts a word this cycle.
- `mem_we` out 1: byte write strobe to instruction memory.
- `mem_addr` out 8: byte write address.
- `mem_wdata` out 8: byte write data.
- `busy` out 1: load in progress.
- `done` out 1: one-cycle pulse at load completion.
- `overflow` out 1: sticky; the address wrapped past 0xFF during the current or last load.

## Operation
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE:
  - `in_ready`=0, `mem_we`=0.
  - On `start`: latch `base`={`start_addr`[7:2],2'b00}, `remaining`=min(`word_count`,`MAX_WORDS`), clear `overflow`.
  - Go to DONE if `remaining`==0, otherwise to ACCEPT.
- ACCEPT:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: capture `in_word` into `word_reg`, `idx`=0, go to WRITE.
  - Without `in_valid`, stay in ACCEPT indefinitely.
- WRITE (4 cycles, `idx`=0..3):
  - `mem_we`=1, `mem_addr`=`base`+`idx` (8-bit, mod 256), `mem_wdata`=`word_reg`[31-8·idx -: 8].
  - `in_ready`=0.
  - After `idx`==3: `base`=`base`+4 (mod 256) and `remaining`-=1.
  - If the increment wraps (`base` was 0xFC) and `remaining`≠0 after the decrement, set `overflow`.
  - Next state: DONE if `remaining`==0, otherwise ACCEPT.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `busy`=1 in ACCEPT, WRITE and DONE; 0 in IDLE.
- `start` outside IDLE is ignored; it is neither queued nor allowed to alter the latched state.
- `in_valid` outside ACCEPT is ignored; the source must hold its word until it sees `in_ready`.
- `overflow` holds its value through IDLE and clears only on the next accepted `start` or on `reset`.
- Reset, including mid-WRITE: next cycle all state returns to IDLE. Outputs after reset: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `overflow`=0. A partially written word is left as is; no further writes occur.

## Timing
- `start` sampled in cycle 0 → ACCEPT in cycle 1 (`in_ready`=1, `busy`=1).
- Handshake in cycle n → byte writes in cycles n+1..n+4 (MSB first).
- Cycle n+5 is either ACCEPT (`in_ready`=1) or DONE (`done`=1).
- `busy` falls in the cycle after `done`.
- Maximum throughput: one word per 5 cycles.
- `word_count`=0: `done` pulses in cycle 1 with no writes; `busy`=1 only in cycle 1.
- `mem_addr`/`mem_wdata` are registered outputs, valid while `mem_we`=1; the memory samples them on the same edge the loader advances.

## Test plan
- Reset → all outputs 0, IDLE; `start` while `reset`=1 has no effect.
- `start`, `start_addr`=0x00, `word_count`=1, word 0x12345678 with `in_valid` held high → writes (0x00,0x12),(0x01,0x34),(0x02,0x56),(0x03,0x78) in consecutive cycles; `done` 5 cycles after the handshake; a read-back through instruction memory returns 0x12345678.
- `start_addr`=0x13, `word_count`=3, `in_valid` toggled randomly → writes start at 0x10; bytes land at 0x10–0x1B in order; `in_ready` never asserted during WRITE; a word is never lost or duplicated.
- `start_addr`=0xF8, `word_count`=3 → writes to 0xF8–0xFF then 0x00–0x03; `overflow`=1 after the second word and still 1 in IDLE; it clears on the next `start`.
- `word_count`=0 → no `mem_we`; `done` pulses in cycle 1. A `start` pulsed during an active load is ignored: the final byte count matches the original request.
- `reset` asserted at the 2nd byte of a word → next cycle `mem_we`=0, `busy`=0, IDLE; only 1 byte of that word was written; a new load then completes normally.
